// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding, fault codes,
// opcode constants/masks and ALU operation codes.
package uc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [5:0] OP_J   = 6'b000100;
  localparam logic [5:0] OP_JZ  = 6'b000101;
  localparam logic [5:0] OP_JNZ = 6'b000110;

  // ALU ops are 1xxxxx, load-immediate is 0000xx
  localparam logic [5:0] MASK_ALU  = 6'b100000;
  localparam logic [5:0] MATCH_ALU = 6'b100000;
  localparam logic [5:0] MASK_LI   = 6'b111100;
  localparam logic [5:0] MATCH_LI  = 6'b000000;

  localparam logic [2:0] ALU_NOP = 3'b000;

  function automatic logic op_match(input logic [5:0] op,
                                    input logic [5:0] mask,
                                    input logic [5:0] match);
    return (op & mask) == match;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode decode: legality plus the datapath controls applied in EXEC.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       legal,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu
);

  always_comb begin
    legal  = 1'b0;
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op_alu = ALU_NOP;
    if (op_match(opcode, MASK_ALU, MATCH_ALU)) begin
      legal  = 1'b1;
      we3    = 1'b1;
      wez    = 1'b1;
      op_alu = opcode[4:2];
    end else if (op_match(opcode, MASK_LI, MATCH_LI)) begin
      legal = 1'b1;
      we3   = 1'b1;
      s_inm = 1'b1;
    end else begin
      case (opcode)
        OP_J: begin
          legal = 1'b1;
          s_inc = 1'b0;
        end
        OP_JZ: begin
          legal = 1'b1;
          s_inc = ~z;
        end
        OP_JNZ: begin
          legal = 1'b1;
          s_inc = z;
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uc_multi.sv
// Multi-cycle instruction controller: fetch with bounded wait, decode, execute, halt on fault.
// state  | meaning
// FETCH  | request instruction, count wait cycles until mem_ready or timeout
// DECODE | check opcode legality, no enables
// EXEC   | drive datapath controls, update PC, retire
// HALT   | stopped with fault cause held until reset
module uc_multi
  import uc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op_alu,
  output logic       retire,
  output logic       halted,
  output logic [1:0] fault
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] fault_q, fault_d;

  logic       dec_legal, dec_s_inc, dec_s_inm, dec_we3, dec_wez;
  logic [2:0] dec_op_alu;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .legal  (dec_legal),
    .s_inc  (dec_s_inc),
    .s_inm  (dec_s_inm),
    .we3    (dec_we3),
    .wez    (dec_wez),
    .op_alu (dec_op_alu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= 8'd0;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // A ready fetch wins over a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_HALT;
          wait_d  = 8'd0;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      ST_EXEC:  state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while reset is held
  always_comb begin
    mem_req = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    op_alu  = ALU_NOP;
    retire  = 1'b0;
    halted  = 1'b0;
    fault   = FAULT_NONE;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXEC: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          s_inc  = dec_s_inc;
          s_inm  = dec_s_inm;
          we3    = dec_we3;
          wez    = dec_wez;
          op_alu = dec_op_alu;
        end
        ST_HALT: begin
          halted = 1'b1;
          fault  = fault_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multi.sv
// Bench for uc_multi: two instances (default timeout and timeout 3) checked every cycle
// against a behavioural model, with directed scenarios followed by random traffic.
module tb_uc_multi;

  logic       clk;
  logic       rst   [2];
  logic [5:0] opc   [2];
  logic       zz    [2];
  logic       mrdy  [2];

  logic       mem_req_w [2];
  logic       ir_we_w   [2];
  logic       pc_we_w   [2];
  logic       s_inc_w   [2];
  logic       s_inm_w   [2];
  logic       we3_w     [2];
  logic       wez_w     [2];
  logic [2:0] op_alu_w  [2];
  logic       retire_w  [2];
  logic       halted_w  [2];
  logic [1:0] fault_w   [2];

  int checks;
  int errors;
  int cyc;

  // model: phase 0 fetch, 1 decode, 2 exec, 3 halt
  int         ph    [2];
  int         cnt   [2];
  logic [1:0] flt   [2];
  int         tmo   [2];
  int         stall [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    uc_multi #(.MEM_TIMEOUT(gi == 0 ? 15 : 3)) dut (
      .clk       (clk),
      .reset     (rst[gi]),
      .opcode    (opc[gi]),
      .z         (zz[gi]),
      .mem_ready (mrdy[gi]),
      .mem_req   (mem_req_w[gi]),
      .ir_we     (ir_we_w[gi]),
      .pc_we     (pc_we_w[gi]),
      .s_inc     (s_inc_w[gi]),
      .s_inm     (s_inm_w[gi]),
      .we3       (we3_w[gi]),
      .wez       (wez_w[gi]),
      .op_alu    (op_alu_w[gi]),
      .retire    (retire_w[gi]),
      .halted    (halted_w[gi]),
      .fault     (fault_w[gi])
    );
  end

  function automatic logic [13:0] obs(input int i);
    return {mem_req_w[i], ir_we_w[i], pc_we_w[i], s_inc_w[i], s_inm_w[i], we3_w[i],
            wez_w[i], op_alu_w[i], retire_w[i], halted_w[i], fault_w[i]};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= 6'd32) || (op <= 6'd6);
  endfunction

  function automatic logic [13:0] model_out(input int i);
    logic mr, ir, pw, si, sm, w3, wz, rt, hl;
    logic [2:0] oa;
    logic [1:0] ft;
    int op;
    mr = 0; ir = 0; pw = 0; si = 1; sm = 0; w3 = 0; wz = 0; rt = 0; hl = 0;
    oa = 3'd0; ft = 2'd0;
    op = int'(opc[i]);
    if (!rst[i]) begin
      if (ph[i] == 0) begin
        mr = 1; ir = mrdy[i];
      end else if (ph[i] == 2) begin
        pw = 1; rt = 1;
        if (op >= 32) begin
          w3 = 1; wz = 1; oa = 3'((op - 32) / 4);
        end else if (op < 4) begin
          w3 = 1; sm = 1;
        end else if (op == 4) si = 0;
        else if (op == 5) si = ~zz[i];
        else if (op == 6) si = zz[i];
      end else if (ph[i] == 3) begin
        hl = 1; ft = flt[i];
      end
    end
    return {mr, ir, pw, si, sm, w3, wz, oa, rt, hl, ft};
  endfunction

  task automatic advance(input int i);
    if (rst[i]) begin
      ph[i] = 0; cnt[i] = 0; flt[i] = 2'b00;
    end else begin
      case (ph[i])
        0: begin
          if (mrdy[i]) begin
            ph[i] = 1; cnt[i] = 0;
          end else if (cnt[i] + 1 >= tmo[i]) begin
            ph[i] = 3; cnt[i] = 0; flt[i] = 2'b10;
          end else cnt[i] = cnt[i] + 1;
        end
        1: begin
          if (is_legal(opc[i])) ph[i] = 2;
          else begin
            ph[i] = 3; flt[i] = 2'b01;
          end
        end
        2: ph[i] = 0;
        default: ph[i] = 3;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // called just after a negedge with inputs set; checks both DUTs, then clocks the models
  task automatic step(input string tag);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s.dut%0d", tag, i), 32'(obs(i)), 32'(model_out(i)));
    @(posedge clk);
    for (int i = 0; i < 2; i++) advance(i);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)      return 6'(32 + $urandom_range(0, 31));
    else if (r < 6) return 6'($urandom_range(0, 3));
    else if (r < 9) return 6'(4 + $urandom_range(0, 2));
    else            return 6'($urandom_range(7, 31));
  endfunction

  initial begin
    int irat, retat;
    checks = 0; errors = 0; cyc = 0;
    tmo[0] = 15; tmo[1] = 3;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; cnt[i] = 0; flt[i] = 2'b00; stall[i] = 0;
      rst[i] = 1; opc[i] = 6'd0; zz[i] = 0; mrdy[i] = 0;
    end
    @(negedge clk);
    step("reset");
    #1 chk("reset_outputs", 32'({mem_req_w[0], s_inc_w[0], pc_we_w[0], halted_w[0]}), 32'h4);
    step("reset");

    // ALU add, ready every fetch
    rst[0] = 0; opc[0] = 6'b101000; mrdy[0] = 1;
    #1 chk("first_mem_req", 32'(mem_req_w[0]), 32'd1);
    step("add_fetch");
    step("add_decode");
    #1 chk("add_exec", 32'({op_alu_w[0], we3_w[0], wez_w[0], pc_we_w[0], retire_w[0]}), 32'h2F);
    step("add_exec");

    // JZ taken then not taken
    opc[0] = 6'b000101; zz[0] = 1;
    step("jz1_fetch"); step("jz1_decode");
    #1 chk("jz_taken", 32'({s_inc_w[0], we3_w[0]}), 32'h0);
    step("jz1_exec");
    zz[0] = 0;
    step("jz0_fetch"); step("jz0_decode");
    #1 chk("jz_not_taken", 32'({s_inc_w[0], we3_w[0]}), 32'h2);
    step("jz0_exec");

    // four stall cycles before the fetch completes
    opc[0] = 6'b100100; mrdy[0] = 0; irat = -1; retat = -1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) mrdy[0] = 1;
      #1;
      if (ir_we_w[0] && irat < 0) irat = k;
      if (retire_w[0] && retat < 0) retat = k;
      step("stall");
    end
    chk("stall_ir_we_cycle", 32'(irat + 1), 32'd5);
    chk("stall_retire_cycle", 32'(retat + 1), 32'd7);

    // illegal opcode halts from decode
    opc[0] = 6'b010000;
    step("ill_fetch"); step("ill_decode");
    #1 chk("illegal_halt", 32'({halted_w[0], fault_w[0], pc_we_w[0], we3_w[0]}), 32'h14);
    step("ill_halt"); step("ill_halt");

    // reset out of HALT
    rst[0] = 1; step("rst_in_halt");
    rst[0] = 0; opc[0] = 6'b000010;
    #1 chk("after_halt_reset", 32'({mem_req_w[0], fault_w[0], halted_w[0]}), 32'h8);
    step("li_fetch"); step("li_decode");
    // reset during EXEC
    rst[0] = 1; step("rst_in_exec");
    rst[0] = 0;
    #1 chk("after_exec_reset", 32'({mem_req_w[0], fault_w[0], halted_w[0]}), 32'h8);
    step("post_exec_fetch");

    // fetch timeout on the MEM_TIMEOUT=3 instance
    rst[0] = 1; rst[1] = 0; mrdy[1] = 0;
    step("tmo_w0"); step("tmo_w1"); step("tmo_w2");
    #1 chk("timeout_halt", 32'({halted_w[1], fault_w[1], mem_req_w[1]}), 32'hC);
    step("tmo_halt");

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 99) == 0) || (ph[i] == 3 && $urandom_range(0, 3) == 0);
        if (ph[i] == 0) opc[i] = pick_op();
        zz[i] = 1'($urandom_range(0, 1));
        if (stall[i] == 0 && $urandom_range(0, 149) == 0) stall[i] = $urandom_range(2, 20);
        if (stall[i] > 0) begin
          mrdy[i] = 0; stall[i]--;
        end else mrdy[i] = ($urandom_range(0, 9) < 6);
      end
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
